// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, the EX/MEM pipeline register layout
// and a saturating-increment helper.
package core_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] rd;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            misalign;
  } ex_mem_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution for branches, JAL and JALR:
// decides taken, computes the target and flags a misaligned (bit 1 set) target.
module branch_resolve
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [6:0]       opcode,
  input  logic             alu_flag,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu_result,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    case (opcode)
      OP_BRANCH: taken = alu_flag;
      OP_JAL:    taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = {alu_result[WIDTH-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  // Only a target we would actually jump to can be misaligned.
  assign misaligned = taken && target[1];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with one-cycle branch/jump redirect and wrong-path kill.
// Optional EX_MEM_BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module ex_mem_stage
  import core_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int REG_ADDR_W = REGW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_flag,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      pc,
  input  logic [WIDTH-1:0]      imm,
  input  logic [WIDTH-1:0]      rs2_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [WIDTH-1:0]      out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [2:0]            out_funct3,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  redirect_valid,
  output logic [WIDTH-1:0]      redirect_pc,
  output logic                  misalign
`ifdef EX_MEM_BRANCH_STATS_EN
  ,
  output logic [31:0]           stat_taken,
  output logic [31:0]           stat_not_taken
`endif
);

  logic             taken;
  logic             misaligned;
  logic [WIDTH-1:0] target;
  logic             is_branch;
  logic             is_jump;
  logic             capture;
  logic             do_redirect;
  ex_mem_t          d;
  ex_mem_t          q;

  branch_resolve #(.WIDTH(WIDTH)) u_branch_resolve (
    .opcode     (opcode),
    .alu_flag   (alu_flag),
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .taken      (taken),
    .target     (target),
    .misaligned (misaligned)
  );

  assign is_branch   = (opcode == OP_BRANCH);
  assign is_jump     = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign in_ready    = !out_valid || out_ready;
  // Anything arriving while a redirect is out is wrong-path: accepted, then dropped.
  assign capture     = in_valid && in_ready && !flush && !redirect_valid;
  assign do_redirect = capture && taken && !misaligned;

  always_comb begin
    d            = '0;
    d.result     = is_jump ? pc + WIDTH'(4) : alu_result;
    d.store_data = rs2_data;
    d.rd         = rd;
    d.funct3     = funct3;
    d.reg_write  = reg_write && !is_branch && !misaligned;
    d.mem_read   = mem_read && !is_branch;
    d.mem_write  = mem_write && !is_branch;
    d.misalign   = misaligned;
  end

  // NOTE: non-blocking assignments for all state; the payload register is reset too
  // because every output must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q              <= '0;
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (capture) q <= d;
      if (flush)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      redirect_valid <= do_redirect;
      if (do_redirect) redirect_pc <= target;
    end
  end

  assign out_result     = q.result;
  assign out_store_data = q.store_data;
  assign out_rd         = q.rd;
  assign out_funct3     = q.funct3;
  assign out_reg_write  = q.reg_write;
  assign out_mem_read   = q.mem_read;
  assign out_mem_write  = q.mem_write;
  assign misalign       = q.misalign;

`ifdef EX_MEM_BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (capture && is_branch) begin
      if (alu_flag) stat_taken     <= sat_inc(stat_taken);
      else          stat_not_taken <= sat_inc(stat_not_taken);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected entries are queued at drive time
// and popped by a negedge monitor on each output handshake.
module tb_ex_mem_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic        alu_flag = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;
`ifdef EX_MEM_BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .alu_flag       (alu_flag),
    .opcode         (opcode),
    .funct3         (funct3),
    .pc             (pc),
    .imm            (imm),
    .rs2_data       (rs2_data),
    .rd             (rd),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_funct3     (out_funct3),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign)
`ifdef EX_MEM_BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  // Inputs are stable at the negedge, so valid&&ready here is exactly the next-edge handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got result=%h rd=%0d with nothing expected", out_result, out_rd);
      end else begin
        e = sb.pop_front();
        if ({out_result, out_store_data, out_rd, out_funct3, out_reg_write, out_mem_read,
             out_mem_write, misalign} !== {e.result, e.sd, e.rd, 3'b010, e.rw, e.mr, e.mw, e.mis}) begin
          n_fail++;
          $display("FAIL sb_entry: got res=%h sd=%h rd=%0d f3=%b rw=%b mr=%b mw=%b mis=%b, expected res=%h sd=%h rd=%0d f3=010 rw=%b mr=%b mw=%b mis=%b",
                   out_result, out_store_data, out_rd, out_funct3, out_reg_write, out_mem_read,
                   out_mem_write, misalign, e.result, e.sd, e.rd, e.rw, e.mr, e.mw, e.mis);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Store data is derived from rd so each entry carries a distinct, predictable payload.
  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic fl,
                       input logic [31:0] p, input logic [31:0] im, input logic [4:0] r,
                       input logic w, input logic m);
    in_valid   = 1'b1;
    opcode     = op;
    alu_result = a;
    alu_flag   = fl;
    pc         = p;
    imm        = im;
    rd         = r;
    reg_write  = w;
    mem_read   = m;
    mem_write  = m;
    funct3     = 3'b010;
    rs2_data   = 32'hCAFE_0000 | {27'd0, r};
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] r, input logic w,
                      input logic m, input logic mis);
    exp_t e;
    e.result = res;
    e.sd     = 32'hCAFE_0000 | {27'd0, r};
    e.rd     = r;
    e.rw     = w;
    e.mr     = m;
    e.mw     = m;
    e.mis    = mis;
    sb.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    if (out_valid !== 1'b0) begin n_tests++; n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    else n_tests++;
    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_misalign", {31'd0, misalign}, 32'd0);
    check("reset_result", out_result, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_fields", {out_store_data[4:0], out_rd, out_funct3, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(OP_RTYPE, 32'h0000_0005, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0);
    push(32'h5, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd5);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_no_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    check("add_drained", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic test_branch();
    // Taken BEQ with reg_write/mem flags asserted on input: all must be forced low.
    drive(OP_BRANCH, 32'h0, 1'b1, 32'h100, 32'h20, 5'd7, 1'b1, 1'b1);
    push(32'h0, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(OP_RTYPE, 32'h99, 1'b0, 32'h104, 32'h0, 5'd9, 1'b1, 1'b0);
    check("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h120);
    check("beq_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("beq_in_ready_in_redirect", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    check("beq_redirect_one_cycle", {31'd0, redirect_valid}, 32'd0);
    check("wrong_path_dropped", {31'd0, out_valid}, 32'd0);
    // Not-taken BNE followed immediately by another instruction.
    drive(OP_BRANCH, 32'h1, 1'b0, 32'h200, 32'h40, 5'd4, 1'b0, 1'b0);
    push(32'h1, 5'd4, 1'b0, 1'b0, 1'b0);
    tick();
    drive(OP_ITYPE, 32'h77, 1'b0, 32'h204, 32'h0, 5'd5, 1'b1, 1'b0);
    push(32'h77, 5'd5, 1'b1, 1'b0, 1'b0);
    check("bne_not_taken_no_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    idle();
    check("after_bne_valid", {31'd0, out_valid}, 32'd1);
    tick();
  endtask

  task automatic test_jumps();
    // JAL at the top of the address space: pc+4 and the target both wrap.
    drive(OP_JAL, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h10, 5'd1, 1'b1, 1'b0);
    push(32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check("jal_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("jal_redirect_pc", redirect_pc, 32'h0000_000C);
    tick();
    drive(OP_JALR, 32'h0000_2001, 1'b0, 32'h40, 32'h0, 5'd2, 1'b1, 1'b0);
    push(32'h44, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check("jalr_redirect_pc", redirect_pc, 32'h2000);
    check("jalr_result", out_result, 32'h44);
    check("jalr_reg_write", {31'd0, out_reg_write}, 32'd1);
    tick();
    // Target 0x2002 has bit 1 set: misaligned, no redirect, no writeback.
    drive(OP_JALR, 32'h0000_2003, 1'b0, 32'h80, 32'h0, 5'd6, 1'b1, 1'b0);
    push(32'h84, 5'd6, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check("jalr_misalign_flag", {31'd0, misalign}, 32'd1);
    check("jalr_misalign_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check("jalr_misalign_reg_write", {31'd0, out_reg_write}, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(OP_RTYPE, 32'h11, 1'b0, 32'h300, 32'h0, 5'd1, 1'b1, 1'b0);
    push(32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(OP_LOAD, 32'h22, 1'b0, 32'h304, 32'h0, 5'd2, 1'b1, 1'b1);
    push(32'h22, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_hold", {out_result[15:0], 3'd0, out_rd, out_funct3, out_valid, out_reg_write, out_mem_read, out_mem_write},
            {16'h0011, 3'd0, 5'd1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0});
      tick();
    end
    out_ready = 1'b1;
    tick();
    idle();
    check("no_bubble_valid", {31'd0, out_valid}, 32'd1);
    check("no_bubble_result", out_result, 32'h22);
    tick();
  endtask

  task automatic test_flush_and_reset();
    drive(OP_BRANCH, 32'h0, 1'b1, 32'h500, 32'h8, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check("flush_no_valid", {31'd0, out_valid}, 32'd0);
    // Redirect fires even while the downstream stage stalls.
    out_ready = 1'b0;
    drive(OP_BRANCH, 32'h3, 1'b1, 32'h400, 32'h10, 5'd8, 1'b0, 1'b0);
    push(32'h3, 5'd8, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("stall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("stall_redirect_pc", redirect_pc, 32'h410);
    tick();
    check("stall_entry_held", {31'd0, out_valid}, 32'd1);
    // Reset while stalled discards the held entry.
    reset = 1'b1;
    void'(sb.pop_back());
    tick();
    check("reset_stall_valid", {31'd0, out_valid}, 32'd0);
    check("reset_stall_result", out_result, 32'd0);
    check("reset_stall_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

`ifdef EX_MEM_BRANCH_STATS_EN
  task automatic test_stats();
    check("stats_cleared", stat_taken | stat_not_taken, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(OP_BRANCH, 32'(i), 1'b1, 32'h600 + 32'(i) * 32'h10, 32'h100, 5'(i), 1'b0, 1'b0);
      push(32'(i), 5'(i), 1'b0, 1'b0, 1'b0);
      tick();
      // A branch in the redirect shadow is wrong-path and must not count.
      drive(OP_BRANCH, 32'hF, 1'b1, 32'h700, 32'h4, 5'd15, 1'b0, 1'b0);
      tick();
      idle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(OP_BRANCH, 32'h20 + 32'(i), 1'b0, 32'h800, 32'h4, 5'd20, 1'b0, 1'b0);
      push(32'h20 + 32'(i), 5'd20, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(OP_BRANCH, 32'h0, 1'b1, 32'h900, 32'h4, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    tick();
    check("stat_taken", stat_taken, 32'd3);
    check("stat_not_taken", stat_not_taken, 32'd2);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_flush_and_reset();
`ifdef EX_MEM_BRANCH_STATS_EN
    test_stats();
`endif
    tick();
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
